wave_amp_ctrl: RTL and testbench

WAVE_AMP_CTRL -- requirements
Module: wave_amp_ctrl

---
 rtl/wave_pkg.sv | 31 +++
 rtl/zc_detect.sv | 43 ++++
 rtl/wave_amp_ctrl.sv | 143 ++++++++++++++
 tb/tb_wave_amp_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wave_pkg.sv
// Shared definitions for the wave amplitude controller: midscale code,
// gain index width, gain FSM state encoding and the target-step helper.
package wave_pkg;

   localparam logic [7:0] MIDSCALE = 8'd128;
   localparam int         GAIN_W   = 3;

   typedef logic [GAIN_W-1:0] gain_t;

   localparam gain_t GAIN_MAX = 3'd7;
   localparam gain_t GAIN_MIN = 3'd0;

   // IDLE: active gain equals target; PEND: a change waits for a crossing
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_PEND = 1'b1
   } gain_state_e;

   // Next target gain from up/down requests; saturating, both = hold
   function automatic gain_t step_target(gain_t cur, logic up, logic dn);
      gain_t nxt;
      nxt = cur;
      if (up && !dn && (cur != GAIN_MAX)) begin
         nxt = cur + gain_t'(1);
      end else if (dn && !up && (cur != GAIN_MIN)) begin
         nxt = cur - gain_t'(1);
      end
      return nxt;
   endfunction

endpackage

// File: rtl/zc_detect.sv
// Zero-crossing detector and pending-change wait counter.
// A crossing is a change of the sample MSB against the previous cycle's
// registered MSB. The counter runs while a gain change is pending and
// flags the forced-apply cycle at ZC_TIMEOUT-1.
module zc_detect #(
   parameter logic [15:0] ZC_TIMEOUT = 16'd65535
) (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic i_msb,
   input  logic i_clr,
   input  logic i_run,
   output logic o_zc,
   output logic o_timeout
);

   logic        r_prev_msb;
   logic [15:0] r_cnt;

   // Remember the previous sample polarity
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_prev_msb <= 1'b0;
      end else begin
         r_prev_msb <= i_msb;
      end
   end

   // Wait counter: held at zero outside PEND and restarted on every apply
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_cnt <= 16'd0;
      end else if (i_clr) begin
         r_cnt <= 16'd0;
      end else if (i_run) begin
         r_cnt <= r_cnt + 16'd1;
      end
   end

   assign o_zc      = i_msb ^ r_prev_msb;
   assign o_timeout = (r_cnt == (ZC_TIMEOUT - 16'd1));

endmodule

// File: rtl/wave_amp_ctrl.sv
// Wave amplitude controller: scales an offset-binary DDS stream by
// (gain_idx+1)/8 with a 2-cycle pipeline, and defers gain changes to the
// next zero crossing (or a timeout) so the DAC output never steps mid
// half-cycle.
// Optional feature: define WAVE_AMP_MUTE_EN to add a 'mute' input that
// forces the output to midscale one cycle later without touching the
// gain state machine.
module wave_amp_ctrl
   import wave_pkg::*;
#(
   parameter gain_t       GAIN_RST   = 3'd7,
   parameter logic [15:0] ZC_TIMEOUT = 16'd65535
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic [7:0] wave_in,
   input  logic       gain_up,
   input  logic       gain_down,
`ifdef WAVE_AMP_MUTE_EN
   input  logic       mute,
`endif
   output logic [7:0] wave_out,
   output logic [2:0] gain_idx,
   output logic       gain_pend
);

   // Offset-binary sample times (g+1)/8, floor rounding; cannot overflow
   function automatic logic [7:0] scale_sample(logic [7:0] smp, gain_t g);
      logic signed [8:0]  s;
      logic signed [4:0]  m;
      logic signed [12:0] p;
      logic signed [12:0] q;
      s = $signed({1'b0, smp}) - 9'sd128;
      m = $signed({2'b00, g}) + 5'sd1;
      p = 13'(s) * 13'(m);
      q = p >>> 3;
      return q[7:0] + MIDSCALE;
   endfunction

   gain_state_e r_state;
   gain_t       r_active;
   gain_t       r_target;
   logic        r_pend;

   logic [7:0]  r_smp_p0;
   gain_t       r_gain_p0;
   logic [7:0]  r_wave_p1;

   gain_t       w_tgt_next;
   logic        w_zc;
   logic        w_timeout;
   logic        w_apply;
   logic        w_cnt_clr;
   logic        w_cnt_run;
   logic        w_mute;

   assign w_tgt_next = step_target(r_target, gain_up, gain_down);
   assign w_apply    = (r_state == ST_PEND) && (w_zc || w_timeout);
   assign w_cnt_clr  = (r_state == ST_IDLE) || w_apply;
   assign w_cnt_run  = (r_state == ST_PEND);

`ifdef WAVE_AMP_MUTE_EN
   assign w_mute = mute;
`else
   assign w_mute = 1'b0;
`endif

   zc_detect #(
      .ZC_TIMEOUT (ZC_TIMEOUT)
   ) u_zc_detect (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .i_msb     (wave_in[7]),
      .i_clr     (w_cnt_clr),
      .i_run     (w_cnt_run),
      .o_zc      (w_zc),
      .o_timeout (w_timeout)
   );

   // Gain FSM: track target, hold active until a crossing or timeout
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_state  <= ST_IDLE;
         r_active <= GAIN_RST;
         r_target <= GAIN_RST;
         r_pend   <= 1'b0;
      end else begin
         r_target <= w_tgt_next;
         case (r_state)
            ST_IDLE: begin
               if (w_tgt_next != r_active) begin
                  r_state <= ST_PEND;
                  r_pend  <= 1'b1;
               end
            end
            ST_PEND: begin
               if (w_apply) begin
                  // apply the target seen this cycle; a same-cycle request stays pending
                  r_active <= r_target;
                  if (w_tgt_next == r_target) begin
                     r_state <= ST_IDLE;
                     r_pend  <= 1'b0;
                  end
               end else if (w_tgt_next == r_active) begin
                  r_state <= ST_IDLE;
                  r_pend  <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_pend  <= 1'b0;
            end
         endcase
      end
   end

   // Stage p0: capture sample together with the gain active this cycle
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_smp_p0  <= MIDSCALE;
         r_gain_p0 <= GAIN_RST;
      end else begin
         r_smp_p0  <= wave_in;
         r_gain_p0 <= r_active;
      end
   end

   // Stage p1: scaled output, forced to midscale while muted
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_wave_p1 <= MIDSCALE;
      end else if (w_mute) begin
         r_wave_p1 <= MIDSCALE;
      end else begin
         r_wave_p1 <= scale_sample(r_smp_p0, r_gain_p0);
      end
   end

   assign wave_out  = r_wave_p1;
   assign gain_idx  = r_active;
   assign gain_pend = r_pend;

endmodule

// File: tb/tb_wave_amp_ctrl.sv
// Testbench for wave_amp_ctrl: hand-written corner sequences, a table of
// scaling vectors at two gains, and randomized traffic against a
// cycle-level reference model of the gain/crossing rules.
module tb_wave_amp_ctrl;

   localparam int T = 16;

   logic       sys_clk = 1'b0;
   logic       sys_rst;
   logic [7:0] wave_in;
   logic       gain_up;
   logic       gain_down;
   logic       mute_drv;
   logic [7:0] wave_out;
   logic [2:0] gain_idx;
   logic       gain_pend;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   int m_active, m_target, m_wait, m_prev, m_s1, m_g1, m_out;

   typedef struct {
      logic [7:0] win;
      int         exp_g7;
      int         exp_g3;
   } vec_t;

   vec_t vecs[8];

   wave_amp_ctrl #(
      .GAIN_RST   (3'd7),
      .ZC_TIMEOUT (16'(T))
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .wave_in   (wave_in),
      .gain_up   (gain_up),
      .gain_down (gain_down),
`ifdef WAVE_AMP_MUTE_EN
      .mute      (mute_drv),
`endif
      .wave_out  (wave_out),
      .gain_idx  (gain_idx),
      .gain_pend (gain_pend)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // floor((x-128)*(g+1)/8) + 128 using plain integer arithmetic
   function automatic int ref_scale(int x, int g);
      int p;
      p = (x - 128) * (g + 1);
      if (p >= 0) return 128 + p / 8;
      return 128 - ((-p + 7) / 8);
   endfunction

   // One clock of the behavioural model, from the inputs seen at the edge
   task automatic model_clock();
      int tn;
      bit zc, pending, apply;
      if (sys_rst) begin
         m_active = 7; m_target = 7; m_wait = 0; m_prev = 0;
         m_s1 = 128; m_g1 = 7; m_out = 128;
      end else begin
         tn = m_target;
         if (gain_up && !gain_down && tn < 7) tn = tn + 1;
         if (gain_down && !gain_up && tn > 0) tn = tn - 1;
         zc      = (int'(wave_in[7]) != m_prev);
         pending = (m_target != m_active);
         apply   = pending && (zc || m_wait == T - 1);
         m_out   = mute_drv ? 128 : ref_scale(m_s1, m_g1);
         m_s1    = int'(wave_in);
         m_g1    = m_active;
         if (apply) begin
            m_active = m_target;
            m_wait   = 0;
         end else if (pending) begin
            m_wait = m_wait + 1;
         end else begin
            m_wait = 0;
         end
         m_target = tn;
         m_prev   = int'(wave_in[7]);
      end
   endtask

   task automatic step();
      @(posedge sys_clk);
      model_clock();
      #1;
      check("model_wave_out", int'(wave_out), m_out);
      check("model_gain_idx", int'(gain_idx), m_active);
      check("model_gain_pend", int'(gain_pend), (m_target != m_active) ? 1 : 0);
   endtask

   initial begin
      int  chg_n;
      int  mcount, mfirst;
      logic msb;
      real sv;

      vecs[0] = '{8'd255, 255, 191};
      vecs[1] = '{8'd0,     0,  64};
      vecs[2] = '{8'd128, 128, 128};
      vecs[3] = '{8'd127, 127, 127};
      vecs[4] = '{8'd200, 200, 164};
      vecs[5] = '{8'd129, 129, 128};
      vecs[6] = '{8'd100, 100, 114};
      vecs[7] = '{8'd64,   64,  96};

      sys_rst = 1'b1; wave_in = 8'd255; gain_up = 1'b0; gain_down = 1'b0; mute_drv = 1'b0;

      // reset: output midscale, unity gain, nothing pending
      repeat (3) step();
      check("rst_wave_out", int'(wave_out), 128);
      check("rst_gain_idx", int'(gain_idx), 7);
      check("rst_gain_pend", int'(gain_pend), 0);

      // first valid output two cycles after release
      sys_rst = 1'b0;
      step();
      check("rel1_wave_out", int'(wave_out), 128);
      step();
      check("rel2_wave_out", int'(wave_out), 255);
      wave_in = 8'd0;
      step(); step();
      check("zero_wave_out", int'(wave_out), 0);

      // scaling table at unity gain
      for (int i = 0; i < 8; i++) begin
         wave_in = vecs[i].win;
         step(); step();
         check("tbl_g7", int'(wave_out), vecs[i].exp_g7);
      end

      // saturation at top and simultaneous requests
      wave_in = 8'd200;
      step(); step();
      gain_up = 1'b1; step(); gain_up = 1'b0;
      check("sat_up_pend", int'(gain_pend), 0);
      check("sat_up_idx", int'(gain_idx), 7);
      gain_up = 1'b1; gain_down = 1'b1; step(); gain_up = 1'b0; gain_down = 1'b0;
      check("both_pend", int'(gain_pend), 0);
      step();
      check("both_idx", int'(gain_idx), 7);

      // four downs with no crossing: applied only on timeout
      gain_down = 1'b1;
      step();
      check("to_pend_first", int'(gain_pend), 1);
      repeat (3) step();
      gain_down = 1'b0;
      for (int i = 0; i < 12; i++) step();
      check("to_idx_hold", int'(gain_idx), 7);
      check("to_pend_hold", int'(gain_pend), 1);
      step();
      check("to_idx_applied", int'(gain_idx), 3);
      check("to_pend_clear", int'(gain_pend), 0);
      step(); step();
      check("to_wave_out", int'(wave_out), 164);

      // scaling table at gain index 3
      for (int i = 0; i < 8; i++) begin
         wave_in = vecs[i].win;
         step(); step();
         check("tbl_g3", int'(wave_out), vecs[i].exp_g3);
      end

      // down then up before any crossing: cancel without applying
      wave_in = 8'd200;
      step(); step();
      gain_down = 1'b1; step(); gain_down = 1'b0;
      check("cancel_pend_on", int'(gain_pend), 1);
      check("cancel_idx_a", int'(gain_idx), 3);
      gain_up = 1'b1; step(); gain_up = 1'b0;
      check("cancel_pend_off", int'(gain_pend), 0);
      step();
      check("cancel_idx_b", int'(gain_idx), 3);

      // sine: one gain_down applies exactly on the falling crossing (sample 17)
      chg_n = -1;
      for (int n = 0; n < 64; n++) begin
         sv = 128.0 + 100.0 * $sin(2.0 * 3.14159265358979 * real'(n) / 32.0);
         wave_in = 8'(int'(sv));
         gain_down = (n == 2);
         step();
         if (chg_n < 0 && gain_idx == 3'd2) chg_n = n;
      end
      gain_down = 1'b0;
      check("sine_apply_sample", chg_n, 17);

      // randomized traffic against the model
      msb = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(23) == 0) msb = ~msb;
         wave_in   = {msb, 7'($urandom)};
         gain_up   = ($urandom_range(9) == 0);
         gain_down = ($urandom_range(9) == 0);
         sys_rst   = ($urandom_range(399) == 0);
         step();
      end
      sys_rst = 1'b0; gain_up = 1'b0; gain_down = 1'b0;

`ifdef WAVE_AMP_MUTE_EN
      // 3-cycle mute on a full-scale square: midscale for exactly 3 cycles, 1 late
      sys_rst = 1'b1; step(); sys_rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         wave_in = (i % 4 < 2) ? 8'd255 : 8'd0;
         step();
      end
      mcount = 0; mfirst = -1;
      for (int i = 0; i < 16; i++) begin
         wave_in  = (i % 4 < 2) ? 8'd255 : 8'd0;
         mute_drv = (i >= 4 && i < 7);
         step();
         if (wave_out == 8'd128) begin
            mcount++;
            if (mfirst < 0) mfirst = i;
         end
      end
      mute_drv = 1'b0;
      check("mute_count", mcount, 3);
      check("mute_first", mfirst, 4);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
